// File: rtl/stream_join_pkg.sv
// Shared types for the dynamic stream join: FSM state encoding.
package stream_join_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

endpackage

// File: rtl/stream_join_lane.sv
// One input lane of the join: payload capture register plus its captured flag.
// data_o reads as zero whenever the lane holds nothing.
module stream_join_lane #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fire_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              cap_o,
  output logic [DATA_W-1:0] data_o
);

  logic              cap_q, cap_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Clear wins: a bypass completion may capture and finish in the same cycle.
  always_comb begin
    cap_d  = cap_q;
    data_d = data_q;
    if (clr_i) begin
      cap_d = 1'b0;
    end else if (fire_i) begin
      cap_d  = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap_q  <= 1'b0;
      data_q <= '0;
    end else begin
      cap_q  <= cap_d;
      data_q <= data_d;
    end
  end

  assign cap_o  = cap_q;
  assign data_o = cap_q ? data_q : '0;

endmodule

// File: rtl/stream_join_dynamic.sv
// Joins the inputs selected by a per-transaction mask into one output beat.
// Optional STREAM_JOIN_DYNAMIC_BYPASS_EN: output valid in the completing COLLECT cycle.
module stream_join_dynamic
  import stream_join_pkg::*;
#(
  parameter int N_INP  = 0,
  parameter int DATA_W = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_INP-1:0]        valid_i,
  output logic [N_INP-1:0]        ready_o,
  input  logic [N_INP*DATA_W-1:0] data_i,
  input  logic [N_INP-1:0]        sel_i,
  input  logic                    sel_valid_i,
  output logic                    sel_ready_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [N_INP*DATA_W-1:0] data_o
);

  state_t           state_q;
  logic [N_INP-1:0] cap, fire, lane_done;
  logic             collect_en, all_done, out_hs;

  assign collect_en = ~rst_i & (state_q == COLLECT) & sel_valid_i;

  for (genvar i = 0; i < N_INP; i++) begin : g_lane
    logic [DATA_W-1:0] lane_data;

    assign ready_o[i]   = collect_en & sel_i[i] & ~cap[i];
    assign fire[i]      = valid_i[i] & ready_o[i];
    // A lane is done if unselected, already held, or handing over this cycle.
    assign lane_done[i] = ~sel_i[i] | cap[i] | fire[i];

    stream_join_lane #(.DATA_W(DATA_W)) u_lane (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .fire_i (fire[i]),
      .clr_i  (out_hs),
      .data_i (data_i[i*DATA_W +: DATA_W]),
      .cap_o  (cap[i]),
      .data_o (lane_data)
    );

`ifdef STREAM_JOIN_DYNAMIC_BYPASS_EN
    assign data_o[i*DATA_W +: DATA_W] = fire[i] ? data_i[i*DATA_W +: DATA_W] : lane_data;
`else
    assign data_o[i*DATA_W +: DATA_W] = lane_data;
`endif
  end

  assign all_done = &lane_done;

`ifdef STREAM_JOIN_DYNAMIC_BYPASS_EN
  assign valid_o = ~rst_i & ((state_q == EMIT) | (collect_en & all_done));
`else
  assign valid_o = ~rst_i & (state_q == EMIT);
`endif

  assign out_hs      = valid_o & ready_i;
  assign sel_ready_o = out_hs;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= COLLECT;
    end else begin
      case (state_q)
        COLLECT: if (collect_en && all_done && !out_hs) state_q <= EMIT;
        EMIT:    if (ready_i) state_q <= COLLECT;
        default: state_q <= COLLECT;
      endcase
    end
  end

endmodule
